// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module  : addsub_pkg
// Purpose : Shared sizing helpers for the carry-pipelined add/sub block.
//           Bits are split into equal chunks, one chunk per pipeline stage;
//           the trailing stages may end up with no bits at all.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package addsub_pkg;

  // The result record holds the sum plus two flags: cout and ovf.
  localparam int RES_FLAG_W = 2;

  // Bits handled by each stage: ceil(w / stages).
  function automatic int chunk_w(input int w, input int stages);
    return (w + stages - 1) / stages;
  endfunction

  // Lowest bit owned by stage k.
  function automatic int slice_lo(input int k, input int chunk);
    return k * chunk;
  endfunction

  // Highest bit owned by stage k. A result below slice_lo marks an empty stage.
  function automatic int slice_hi(input int k, input int chunk, input int w);
    int top;
    top = (k + 1) * chunk;
    if (top > w) top = w;
    return top - 1;
  endfunction

  // Width of the packed {sum, cout, ovf} result record.
  function automatic int res_w(input int w);
    return w + RES_FLAG_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_addsub_if.sv
`default_nettype none
// ============================================================================
// Module  : pipelined_addsub_if
// Purpose : Operand and result streams of the pipelined add/sub block.
// Ports   : in_valid/in_ready/a/b/cin/sub   operand beat (producer -> block)
//           out_valid/out_ready/sum/cout/ovf result beat (block -> consumer)
//           master = producer/consumer side, slave = the adder itself
// Rev     : 1.0  initial release
// ============================================================================
interface pipelined_addsub_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface
`default_nettype wire

// File: rtl/addsub_slice.sv
`default_nettype none
// ============================================================================
// Module  : addsub_slice
// Purpose : Combinational ripple of CW full-adder cells for one bit-slice.
// Ports   : a, b_eff     slice operands (b already inverted for subtract)
//           carry_in     carry entering bit 0 of the slice
//           sum          slice sum bits
//           carry_out    carry leaving the top bit of the slice
//           carry_top    carry entering the top bit (used for overflow)
// Rev     : 1.0  initial release
// ============================================================================
module addsub_slice #(
  parameter int CW = 2
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b_eff,
  input  logic          carry_in,
  output logic [CW-1:0] sum,
  output logic          carry_out,
  output logic          carry_top
);

  // Carry is rippled through a block-local variable so the chain stays a
  // single combinational process instead of a self-referencing vector.
  logic carry;

  always_comb begin
    sum       = '0;
    carry     = carry_in;
    carry_top = carry_in;
    for (int i = 0; i < CW; i++) begin
      if (i == CW - 1) carry_top = carry;
      sum[i] = a[i] ^ b_eff[i] ^ carry;
      carry  = (a[i] & b_eff[i]) | (carry & (a[i] ^ b_eff[i]));
    end
    carry_out = carry;
  end

endmodule
`default_nettype wire

// File: rtl/pipelined_addsub.sv
`default_nettype none
// ============================================================================
// Module  : pipelined_addsub
// Purpose : W-bit adder/subtractor with a STAGES-deep carry-pipelined ripple
//           chain, one operation per cycle, valid/ready on both sides.
// Ports   : clk   rising-edge clock
//           rst   synchronous active-high reset
//           bus   slave side of pipelined_addsub_if (operands in, result out)
// Rev     : 1.0  initial release
// ============================================================================
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int W      = 8,
  parameter int STAGES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  pipelined_addsub_if.slave     bus
);

  localparam int CHUNK = chunk_w(W, STAGES);
  localparam int LAST  = STAGES - 1;

  // Per-stage registers: skewed operands, partial sum, carry, carry into MSB.
  logic [W-1:0] a_q [STAGES];
  logic [W-1:0] a_d [STAGES];
  logic [W-1:0] b_q [STAGES];
  logic [W-1:0] b_d [STAGES];
  logic [W-1:0] s_q [STAGES];
  logic [W-1:0] s_d [STAGES];
  logic         v_q [STAGES];
  logic         v_d [STAGES];
  logic         c_q [STAGES];
  logic         c_d [STAGES];
  logic         m_q [STAGES];
  logic         m_d [STAGES];

  // What each stage sees at its input, and what its slice produces.
  logic [W-1:0] st_a   [STAGES];
  logic [W-1:0] st_b   [STAGES];
  logic [W-1:0] st_s   [STAGES];
  logic         st_v   [STAGES];
  logic         st_c   [STAGES];
  logic         st_m   [STAGES];
  logic [W-1:0] sl_sum [STAGES];
  logic         sl_c   [STAGES];
  logic         sl_m   [STAGES];

  logic                 advance;
  logic [res_w(W)-1:0]  res;

  // The whole pipe moves as one unit; it only freezes when a finished
  // result is waiting and the consumer refuses it.
  assign advance      = !v_q[LAST] || bus.out_ready;
  assign bus.in_ready = advance;

  always_comb begin : stage_inputs
    // Subtraction is A + ~B + ~borrow, so invert b and cin up front.
    st_a[0] = bus.a;
    st_b[0] = bus.sub ? ~bus.b : bus.b;
    st_s[0] = '0;
    st_v[0] = bus.in_valid;
    st_c[0] = bus.sub ^ bus.cin;
    st_m[0] = 1'b0;
    for (int k = 1; k < STAGES; k++) begin
      st_a[k] = a_q[k-1];
      st_b[k] = b_q[k-1];
      st_s[k] = s_q[k-1];
      st_v[k] = v_q[k-1];
      st_c[k] = c_q[k-1];
      st_m[k] = m_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = slice_lo(k, CHUNK);
    localparam int HI = slice_hi(k, CHUNK, W);

    if (LO <= W - 1) begin : g_slice
      localparam int CW = HI - LO + 1;
      logic [CW-1:0] part_sum;
      logic          part_cout;
      logic          part_ctop;

      addsub_slice #(.CW(CW)) u_slice (
        .a         (st_a[k][HI:LO]),
        .b_eff     (st_b[k][HI:LO]),
        .carry_in  (st_c[k]),
        .sum       (part_sum),
        .carry_out (part_cout),
        .carry_top (part_ctop)
      );

      assign sl_sum[k] = W'(part_sum) << LO;
      assign sl_c[k]   = part_cout;
      // Only the slice holding bit W-1 knows the carry into the MSB.
      assign sl_m[k]   = (HI == W - 1) ? part_ctop : st_m[k];
    end else begin : g_pass
      // No bits left for this stage: it is a pure delay element.
      assign sl_sum[k] = '0;
      assign sl_c[k]   = st_c[k];
      assign sl_m[k]   = st_m[k];
    end
  end

  always_comb begin : stage_next
    for (int k = 0; k < STAGES; k++) begin
      a_d[k] = st_a[k];
      b_d[k] = st_b[k];
      v_d[k] = st_v[k];
      s_d[k] = st_s[k] | sl_sum[k];
      c_d[k] = sl_c[k];
      m_d[k] = sl_m[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        m_q[k] <= 1'b0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        v_q[k] <= v_d[k];
        c_q[k] <= c_d[k];
        m_q[k] <= m_d[k];
      end
    end
  end

  // Signed overflow: carry into the MSB disagrees with carry out of it.
  assign res           = {s_q[LAST], c_q[LAST], m_q[LAST] ^ c_q[LAST]};
  assign bus.sum       = res[W+1:2];
  assign bus.cout      = res[1];
  assign bus.ovf       = res[0];
  assign bus.out_valid = v_q[LAST];

endmodule
`default_nettype wire
